// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM with hardware init engine.
package ram_pkg;

    typedef enum logic {ST_CLEAR, ST_IDLE} ram_state_t;

    // Reset always restarts the fill so the array never powers up undefined.
    localparam ram_state_t RST_STATE = ST_CLEAR;

    function automatic logic addr_ok(input int addr, input int depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Storage array with one write port and a registered read port with write-first bypass.
module ram_dp_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; the init engine clears it instead.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            rdata <= '0;
        else if (re)
            rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/ram_dp_init.sv
// Simple-dual-port RAM top: init FSM, fill pointer, port muxing and range/error checking.
module ram_dp_init
    import ram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 5,
    parameter int                DEPTH    = 1 << ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_req,
    output logic              busy,
    input  logic              wr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              err
);

    ram_state_t        state;
    logic [ADDR_W-1:0] ptr;
    logic              sel_init;
    logic [DATA_W-1:0] core_rdata;

    logic clear, w_in, r_in, wr_ok, rd_ok;
    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;

    assign clear = (state == ST_CLEAR);
    assign w_in  = addr_ok(int'(waddr), DEPTH);
    assign r_in  = addr_ok(int'(raddr), DEPTH);
    assign wr_ok = !clear && wr && w_in;
    assign rd_ok = !clear && rd && r_in;

    // The fill engine owns the write port while clearing; user writes are muxed off.
    assign core_we    = reset && (clear || wr_ok);
    assign core_waddr = clear ? ptr : waddr;
    assign core_wdata = clear ? INIT_VAL : wdata;

    ram_dp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (rd_ok),
        .raddr (raddr),
        .rdata (core_rdata)
    );

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RST_STATE;
            ptr      <= '0;
            dout_vld <= 1'b0;
            err      <= 1'b0;
            sel_init <= 1'b0;
        end else if (clear) begin
            dout_vld <= 1'b0;
            err      <= wr || rd;
            if (ptr == ADDR_W'(DEPTH - 1)) begin
                state <= ST_IDLE;
            end else begin
                ptr <= ptr + ADDR_W'(1);
            end
        end else begin
            dout_vld <= rd;
            err      <= (wr && !w_in) || (rd && !r_in);
            if (rd) sel_init <= !r_in;
            if (init_req) begin
                state <= ST_CLEAR;
                ptr   <= '0;
            end
        end
    end

    assign busy = clear;
    // Out-of-range reads return INIT_VAL and that value is held until the next read.
    assign dout = sel_init ? INIT_VAL : core_rdata;

endmodule

// File: tb/tb_ram_dp_init.sv
// Directed bench for ram_dp_init: default 32x8 instance plus a DEPTH=24 instance for range checks.
module tb_ram_dp_init;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       reset, init_req, wr, rd;
    logic [4:0] waddr, raddr;
    logic [7:0] wdata, dout;
    logic       busy, dout_vld, err;

    logic       s_reset, s_init_req, s_wr, s_rd;
    logic [4:0] s_waddr, s_raddr;
    logic [7:0] s_wdata, s_dout;
    logic       s_busy, s_dout_vld, s_err;

    always #5 clk = ~clk;

    ram_dp_init u_dut (
        .clk(clk), .reset(reset), .init_req(init_req), .busy(busy),
        .wr(wr), .waddr(waddr), .wdata(wdata),
        .rd(rd), .raddr(raddr),
        .dout(dout), .dout_vld(dout_vld), .err(err)
    );

    ram_dp_init #(.DATA_W(8), .ADDR_W(5), .DEPTH(24), .INIT_VAL(8'h5A)) u_dut24 (
        .clk(clk), .reset(s_reset), .init_req(s_init_req), .busy(s_busy),
        .wr(s_wr), .waddr(s_waddr), .wdata(s_wdata),
        .rd(s_rd), .raddr(s_raddr),
        .dout(s_dout), .dout_vld(s_dout_vld), .err(s_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, dout, dout_vld, err} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: busy/dout/vld/err got %b/%h/%b/%b want 1/00/0/0", busy, dout, dout_vld, err);
        end
        reset = 1'b1;
        count_busy(n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d cycles want 32", n);
        end
        for (int i = 0; i < 32; i++) begin
            rd = 1'b1;
            raddr = 5'(i);
            tick();
            checks++;
            if ({dout, dout_vld, err} !== {8'h00, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_fill addr %0d: dout/vld/err got %h/%b/%b want 00/1/0", i, dout, dout_vld, err);
            end
        end
        rd = 1'b0;
        tick();
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL vld_idle: got %b want 0", dout_vld);
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1;
            waddr = 5'(i);
            wdata = 8'(i);
            tick();
            checks++;
            if ({dout_vld, err} !== 2'b00) begin
                errors++;
                $display("FAIL write addr %0d: vld/err got %b/%b want 0/0", i, dout_vld, err);
            end
        end
        wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd = 1'b1;
            raddr = 5'(i);
            tick();
            checks++;
            if ({dout, dout_vld, err} !== {8'(i), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL readback addr %0d: dout/vld/err got %h/%b/%b want %h/1/0", i, dout, dout_vld, err, 8'(i));
            end
        end
        rd = 1'b0;
        tick();
        checks++;
        if ({dout, dout_vld} !== {8'h0F, 1'b0}) begin
            errors++;
            $display("FAIL dout_hold: dout/vld got %h/%b want 0f/0", dout, dout_vld);
        end
    endtask

    task automatic test_collision();
        wr = 1'b1; waddr = 5'd5; wdata = 8'hA5;
        rd = 1'b1; raddr = 5'd5;
        tick();
        checks++;
        if ({dout, dout_vld, err} !== {8'hA5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL collision_wfirst: dout/vld/err got %h/%b/%b want a5/1/0", dout, dout_vld, err);
        end
        waddr = 5'd6; wdata = 8'h77; raddr = 5'd4;
        tick();
        checks++;
        if (dout !== 8'h04) begin
            errors++;
            $display("FAIL diff_addr_rw: dout got %h want 04", dout);
        end
        wr = 1'b0; raddr = 5'd6;
        tick();
        checks++;
        if (dout !== 8'h77) begin
            errors++;
            $display("FAIL diff_addr_written: dout got %h want 77", dout);
        end
        raddr = 5'd5;
        tick();
        checks++;
        if (dout !== 8'hA5) begin
            errors++;
            $display("FAIL collision_stored: dout got %h want a5", dout);
        end
        rd = 1'b0;
    endtask

    task automatic test_init_req();
        int n;
        wr = 1'b1; waddr = 5'd7; wdata = 8'h3C;
        tick();
        wr = 1'b0; rd = 1'b1; raddr = 5'd7;
        tick();
        checks++;
        if (dout !== 8'h3C) begin
            errors++;
            $display("FAIL pre_init_read: dout got %h want 3c", dout);
        end
        rd = 1'b0; init_req = 1'b1;
        tick();
        init_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL init_busy: got %b want 1", busy);
        end
        // Three rejected accesses while clearing: write, write+read, read.
        for (int k = 0; k < 3; k++) begin
            wr = (k != 2); waddr = 5'd7; wdata = 8'h55;
            rd = (k != 0); raddr = 5'd7;
            tick();
            checks++;
            if ({err, dout_vld, dout} !== {1'b1, 1'b0, 8'h3C}) begin
                errors++;
                $display("FAIL busy_reject %0d: err/vld/dout got %b/%b/%h want 1/0/3c", k, err, dout_vld, dout);
            end
        end
        wr = 1'b0; rd = 1'b0; init_req = 1'b1;
        tick();
        init_req = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL busy_err_clear: got %b want 0", err);
        end
        count_busy(n);
        checks++;
        if (n !== 28) begin
            errors++;
            $display("FAIL init_busy_len: remaining got %0d want 28 (init_req during busy must not restart)", n);
        end
        rd = 1'b1; raddr = 5'd7;
        tick();
        checks++;
        if ({dout, dout_vld} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL post_init_addr7: dout/vld got %h/%b want 00/1", dout, dout_vld);
        end
        raddr = 5'd5;
        tick();
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL post_init_addr5: dout got %h want 00", dout);
        end
        rd = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        for (int i = 0; i < 32; i++) begin
            wr = 1'b1; waddr = 5'(i); wdata = 8'hE0 | 8'(i);
            tick();
        end
        wr = 1'b0; rd = 1'b1; raddr = 5'd3;
        tick();
        rd = 1'b0;
        checks++;
        if (dout !== 8'hE3) begin
            errors++;
            $display("FAIL pre_reset_read: dout got %h want e3", dout);
        end
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_busy: got %b want 1", busy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, dout} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL mid_reset_state: busy/dout got %b/%h want 1/00", busy, dout);
        end
        reset = 1'b1;
        count_busy(n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL mid_reset_busy_len: got %0d want 32", n);
        end
        for (int i = 0; i < 32; i++) begin
            rd = 1'b1; raddr = 5'(i);
            tick();
            checks++;
            if ({dout, dout_vld} !== {8'h00, 1'b1}) begin
                errors++;
                $display("FAIL mid_reset_fill addr %0d: dout/vld got %h/%b want 00/1", i, dout, dout_vld);
            end
        end
        rd = 1'b0;
    endtask

    task automatic test_out_of_range();
        int n;
        s_reset = 1'b0;
        tick();
        s_reset = 1'b1;
        n = 0;
        while (s_busy && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 24) begin
            errors++;
            $display("FAIL d24_busy_len: got %0d want 24", n);
        end
        s_wr = 1'b1; s_waddr = 5'd3; s_wdata = 8'h11;
        tick();
        s_waddr = 5'd30; s_wdata = 8'hFF;
        tick();
        s_wr = 1'b0;
        checks++;
        if ({s_err, s_dout_vld} !== 2'b10) begin
            errors++;
            $display("FAIL d24_oor_write: err/vld got %b/%b want 1/0", s_err, s_dout_vld);
        end
        s_rd = 1'b1; s_raddr = 5'd3;
        tick();
        checks++;
        if ({s_dout, s_dout_vld, s_err} !== {8'h11, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL d24_inrange_read: dout/vld/err got %h/%b/%b want 11/1/0", s_dout, s_dout_vld, s_err);
        end
        s_raddr = 5'd30;
        tick();
        checks++;
        if ({s_dout, s_dout_vld, s_err} !== {8'h5A, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL d24_oor_read: dout/vld/err got %h/%b/%b want 5a/1/1", s_dout, s_dout_vld, s_err);
        end
        s_rd = 1'b0;
        tick();
        checks++;
        if ({s_dout, s_dout_vld, s_err} !== {8'h5A, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL d24_oor_hold: dout/vld/err got %h/%b/%b want 5a/0/0", s_dout, s_dout_vld, s_err);
        end
        s_wr = 1'b1; s_waddr = 5'd30; s_wdata = 8'hFF;
        s_rd = 1'b1; s_raddr = 5'd31;
        tick();
        s_wr = 1'b0; s_rd = 1'b0;
        checks++;
        if ({s_err, s_dout_vld} !== 2'b11) begin
            errors++;
            $display("FAIL d24_both_oor: err/vld got %b/%b want 1/1", s_err, s_dout_vld);
        end
        tick();
        checks++;
        if (s_err !== 1'b0) begin
            errors++;
            $display("FAIL d24_single_pulse: err got %b want 0", s_err);
        end
        // Boundary: write to DEPTH rejected while an in-range read still completes.
        s_wr = 1'b1; s_waddr = 5'd24; s_wdata = 8'hC3;
        s_rd = 1'b1; s_raddr = 5'd23;
        tick();
        s_wr = 1'b0;
        checks++;
        if ({s_dout, s_dout_vld, s_err} !== {8'h5A, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL d24_boundary: dout/vld/err got %h/%b/%b want 5a/1/1", s_dout, s_dout_vld, s_err);
        end
        for (int i = 0; i < 8; i++) begin
            s_raddr = 5'(i);
            tick();
            checks++;
            if (s_dout !== ((i == 3) ? 8'h11 : 8'h5A)) begin
                errors++;
                $display("FAIL d24_no_alias addr %0d: dout got %h want %h", i, s_dout, (i == 3) ? 8'h11 : 8'h5A);
            end
        end
        s_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b0; init_req = 1'b0; wr = 1'b0; rd = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;
        s_reset = 1'b0; s_init_req = 1'b0; s_wr = 1'b0; s_rd = 1'b0;
        s_waddr = '0; s_raddr = '0; s_wdata = '0;
        test_reset();
        test_write_read();
        test_collision();
        test_init_req();
        test_reset_mid_clear();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
